// File: rtl/comp_serial_pkg.sv
// comp_serial_pkg: shared types for the bit-serial magnitude comparator.
//   state_e  : FSM encodings (IDLE=0, SHIFT=1, DONE=2), matching the
//              encodings used by the parallel comparator bench.
//   rel_e    : running relation (EQ=0, GT=1, LT=2).
//   result_t : registered greater/lesser/equal output triple.
//   rel_decode converts a relation into the one-hot output triple.
package comp_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_e;

    typedef struct packed {
        logic greater;
        logic lesser;
        logic equal;
    } result_t;

    function automatic result_t rel_decode(input rel_e r);
        result_t res;
        res.greater = (r == REL_GT);
        res.lesser  = (r == REL_LT);
        res.equal   = (r == REL_EQ);
        return res;
    endfunction

endpackage

// File: rtl/comp_serial_if.sv
// comp_serial_if: serial operand link plus result outputs.
//   start, bit_valid, a_bit, b_bit : driven by the operand source (master)
//   busy, done, greater, lesser, equal : driven by the comparator (slave)
interface comp_serial_if;

    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic greater;
    logic lesser;
    logic equal;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, greater, lesser, equal
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, greater, lesser, equal
    );

endinterface

// File: rtl/comp_serial.sv
// comp_serial: bit-serial, MSB-first magnitude comparator.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : comp_serial_if.slave
//           start      - begin comparison (honoured in IDLE only)
//           bit_valid  - a_bit/b_bit valid (honoured in SHIFT only)
//           a_bit/b_bit- operand bits, MSB first
//           busy       - high in SHIFT and DONE
//           done       - one-cycle pulse, result valid from this cycle
//           greater/lesser/equal - registered result, held until next done
// Parameter WIDTH (1..32): operand width.
// Build option COMP_SERIAL_SIGNED_EN: two's-complement compare (the first
// beat carries the sign bit, so its decision is inverted).
module comp_serial
    import comp_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    comp_serial_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    rel_e            rel_q,   rel_d;
    result_t         res_q,   res_d;

    rel_e            beat_rel;
    rel_e            next_rel;

    // Relation decided by the current bit pair alone.
`ifdef COMP_SERIAL_SIGNED_EN
    logic sign_beat;
    assign sign_beat = (count_q == CW'(WIDTH));

    always_comb begin
        beat_rel = REL_EQ;
        if (bus.a_bit != bus.b_bit) begin
            // On the sign beat a set bit means negative, i.e. the smaller value.
            beat_rel = (bus.a_bit ^ sign_beat) ? REL_GT : REL_LT;
        end
    end
`else
    always_comb begin
        beat_rel = REL_EQ;
        if (bus.a_bit != bus.b_bit) begin
            beat_rel = bus.a_bit ? REL_GT : REL_LT;
        end
    end
`endif

    // First differing bit wins; later bits are consumed but do not change it.
    assign next_rel = (rel_q == REL_EQ) ? beat_rel : rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rel_q   <= REL_EQ;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rel_q   <= rel_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rel_d   = rel_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    count_d = CW'(WIDTH);
                    rel_d   = REL_EQ;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_valid) begin
                    count_d = count_q - CW'(1);
                    rel_d   = next_rel;
                    if (count_q == CW'(1)) begin
                        // Load the result on entry to DONE so it is visible with done.
                        state_d = ST_DONE;
                        res_d   = rel_decode(next_rel);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = (state_q == ST_DONE);
        bus.greater = res_q.greater;
        bus.lesser  = res_q.lesser;
        bus.equal   = res_q.equal;
    end

endmodule

// File: tb/tb_comp_serial.sv
// tb_comp_serial: self-checking bench for comp_serial (WIDTH=2).
// Expected results come from an arithmetic model of the operands.
`timescale 1ns/1ps
module tb_comp_serial;

    localparam int W = 2;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    int   done_cnt;
    logic [2:0] last_exp;

    comp_serial_if bus ();

    comp_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
    end

    typedef struct {
        int         a;
        int         b;
        logic [2:0] exp;   // {greater, lesser, equal}
    } vec_t;

    vec_t tbl[16];

    // Reference: interpret operands as integers and compare them.
    function automatic logic [2:0] model(input int a, input int b);
        int sa;
        int sb;
        sa = a;
        sb = b;
`ifdef COMP_SERIAL_SIGNED_EN
        if (a >= (1 << (W - 1))) sa = a - (1 << W);
        if (b >= (1 << (W - 1))) sb = b - (1 << W);
`endif
        if (sa > sb) return 3'b100;
        if (sa < sb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [2:0] res();
        return {bus.greater, bus.lesser, bus.equal};
    endfunction

    // One full comparison from IDLE; random stall of 0..gap_max cycles before each beat.
    task automatic run_cmp(input int a, input int b, input int gap_max, input string tag);
        logic [2:0] exp;
        int         d0;
        logic       frame_ok;
        exp      = model(a, b);
        d0       = done_cnt;
        frame_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) frame_ok = 1'b0;
                bus.bit_valid = 1'b0;
                bus.a_bit     = $urandom_range(1, 0) == 1;
                bus.b_bit     = $urandom_range(1, 0) == 1;
                @(negedge clk);
            end
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) frame_ok = 1'b0;
            bus.bit_valid = 1'b1;
            bus.a_bit     = ((a >> i) & 1) == 1;
            bus.b_bit     = ((b >> i) & 1) == 1;
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        check({tag, "_frame"}, {31'd0, frame_ok}, 32'd1);
        check({tag, "_done"}, {30'd0, bus.done, bus.busy}, 32'd3);
        check({tag, "_result"}, {29'd0, res()}, {29'd0, exp});
        @(negedge clk);
        check({tag, "_after"}, {29'd0, bus.done, bus.busy, res() == exp}, 32'd1);
        check({tag, "_ndone"}, done_cnt - d0, 32'd1);
        last_exp = exp;
    endtask

    initial begin
        int d0;
        tests     = 0;
        failed    = 0;
        done_cnt  = 0;
        last_exp  = 3'b000;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bit_valid = 1'b0;
        bus.a_bit = 1'b0;
        bus.b_bit = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].a   = i / 4;
            tbl[i].b   = i % 4;
            tbl[i].exp = model(i / 4, i % 4);
        end

        #1;
        check("reset_outputs", {27'd0, bus.busy, bus.done, res()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // bit_valid in IDLE before any comparison: nothing happens
        for (int k = 0; k < 3; k++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit = k[0];
            bus.b_bit = ~k[0];
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        check("idle_pulse_pre", {27'd0, bus.busy, bus.done, res()}, 32'd0);
        check("idle_pulse_pre_ndone", done_cnt, 32'd0);

        // exhaustive table, no stalls
        foreach (tbl[i]) begin
            run_cmp(tbl[i].a, tbl[i].b, 0, $sformatf("tbl_a%0d_b%0d", tbl[i].a, tbl[i].b));
            check($sformatf("tbl_onehot_%0d", i), {31'd0, $onehot(res())}, 32'd1);
        end

        // a=10, b=01 with 3-cycle gaps between beats
        begin
            int gd0;
            gd0 = done_cnt;
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
            @(negedge clk);
            bus.bit_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                check("gap_busy", {30'd0, bus.busy, bus.done}, 32'd2);
                @(negedge clk);
            end
            bus.bit_valid = 1'b1; bus.a_bit = 1'b0; bus.b_bit = 1'b1;
            @(negedge clk);
            bus.bit_valid = 1'b0;
            check("gap_done", {30'd0, bus.busy, bus.done}, 32'd3);
`ifdef COMP_SERIAL_SIGNED_EN
            check("gap_result", {29'd0, res()}, 32'b010);
`else
            check("gap_result", {29'd0, res()}, 32'b100);
`endif
            @(negedge clk);
            check("gap_ndone", done_cnt - gd0, 32'd1);
            last_exp = model(2, 1);
        end

        // start held high through SHIFT and DONE, a=11 b=11
        begin
            int sd0;
            sd0 = done_cnt;
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b1;
                @(negedge clk);
            end
            bus.bit_valid = 1'b0;
            check("hold_done", {30'd0, bus.busy, bus.done}, 32'd3);
            check("hold_equal", {29'd0, res()}, 32'b001);
            @(negedge clk);
            check("hold_idle_gap", {30'd0, bus.busy, bus.done}, 32'd0);
            @(negedge clk);
            check("hold_restart", {30'd0, bus.busy, bus.done}, 32'd2);
            check("hold_ndone", done_cnt - sd0, 32'd1);
            bus.start = 1'b0;
            bus.bit_valid = 1'b1; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
            @(negedge clk);
            bus.a_bit = 1'b0; bus.b_bit = 1'b1;
            @(negedge clk);
            bus.bit_valid = 1'b0;
            check("hold_second", {29'd0, res()}, {29'd0, model(0, 1)});
            @(negedge clk);
            last_exp = model(0, 1);
        end

        // reset mid-SHIFT on a=11, b=00
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {27'd0, bus.busy, bus.done, res()}, 32'd0);
        @(negedge clk);
        bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
        @(negedge clk);
        bus.bit_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_nodone", done_cnt - d0, 32'd0);
        check("rst_mid_idle", {27'd0, bus.busy, bus.done, res()}, 32'd0);
        run_cmp(0, 3, 0, "post_rst");
`ifndef COMP_SERIAL_SIGNED_EN
        check("post_rst_lesser", {29'd0, res()}, 32'b010);
`endif

        // randomized operands and stalls
        for (int r = 0; r < 40; r++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(3, 0));
            rb = int'($urandom_range(3, 0));
            run_cmp(ra, rb, 2, $sformatf("rnd%0d_a%0d_b%0d", r, ra, rb));
        end

        // bit_valid in IDLE after a completed comparison: outputs hold
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) begin
            bus.bit_valid = 1'b1;
            bus.a_bit = k[1];
            bus.b_bit = k[0];
            @(negedge clk);
        end
        bus.bit_valid = 1'b0;
        check("idle_pulse_post", {27'd0, bus.busy, bus.done, res()}, {27'd0, 2'b00, last_exp});
        check("idle_pulse_post_ndone", done_cnt - d0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
